// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Avalon-MM master that reprograms the system PLL via the reconfiguration
//   core. It encodes N/M/C0/C1 divide ratios into counter words and writes them
//   in polling mode. It then triggers reconfiguration and polls status until
//   done. Finally it waits for the PLL to hold lock for 16 consecutive cycles.
//
// Ports
//   clk, rst_n            management clock, async active-low reset
//   cfg_start             start request (sampled in IDLE only)
//   cfg_n/m/c0/c1         divide ratios, 0 treated as 1, captured at start
//   busy / done / error   status: busy span, completion pulse, sticky timeout
//   mgmt_*                Avalon-MM master to the reconfig core
//   pll_locked            async lock indication from the PLL
module pll_reconfig_ctrl #(
    parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [7:0]  cfg_n,
    input  logic [7:0]  cfg_m,
    input  logic [7:0]  cfg_c0,
    input  logic [7:0]  cfg_c1,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1,
        S_START, S_POLL, S_LOCK, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic        r_busy, r_done, r_error, r_write, r_read;
    logic [5:0]  r_addr;
    logic [31:0] r_wdata;
    logic [17:0] r_enc_n, r_enc_m, r_enc_c0, r_enc_c1;
    logic [19:0] r_to;
    logic [3:0]  r_lcnt;
    logic        r_lock_s1, r_lock_s2;

    logic [5:0]  w_addr;
    logic [31:0] w_data;
    state_t      w_next;
    logic        w_unused;

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign mgmt_address   = r_addr;
    assign mgmt_write     = r_write;
    assign mgmt_read      = r_read;
    assign mgmt_writedata = r_wdata;
    assign w_unused       = ^mgmt_readdata[31:1];

    // Counter word {odd, bypass, hi, lo}. Bypass still carries the computed
    // hi/lo/odd so the core sees a consistent divider if bypass is later cleared.
    function automatic logic [17:0] f_enc(input logic [7:0] d);
        logic [7:0] v;
        logic [8:0] hi;
        v     = (d == 8'd0) ? 8'd1 : d;
        hi    = ({1'b0, v} + 9'd1) >> 1;
        f_enc = {v[0], (v == 8'd1), hi[7:0], 1'b0, v[7:1]};
    endfunction

    // Address/data/successor for each write state.
    always_comb begin
        w_addr = 6'd0;
        w_data = 32'd0;
        w_next = S_IDLE;
        case (r_state)
            S_MODE:  begin w_addr = 6'd0; w_data = 32'd1;                      w_next = S_WR_N;  end
            S_WR_N:  begin w_addr = 6'd3; w_data = {14'd0, r_enc_n};           w_next = S_WR_M;  end
            S_WR_M:  begin w_addr = 6'd4; w_data = {14'd0, r_enc_m};           w_next = S_WR_C0; end
            S_WR_C0: begin w_addr = 6'd5; w_data = {9'd0, 5'd0, r_enc_c0};     w_next = S_WR_C1; end
            S_WR_C1: begin w_addr = 6'd5; w_data = {9'd0, 5'd1, r_enc_c1};     w_next = S_START; end
            S_START: begin w_addr = 6'd2; w_data = 32'd0;                      w_next = S_POLL;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_write   <= 1'b0;
            r_read    <= 1'b0;
            r_addr    <= 6'd0;
            r_wdata   <= 32'd0;
            r_enc_n   <= 18'd0;
            r_enc_m   <= 18'd0;
            r_enc_c0  <= 18'd0;
            r_enc_c1  <= 18'd0;
            r_to      <= 20'd0;
            r_lcnt    <= 4'd0;
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: if (cfg_start) begin
                    r_enc_n  <= f_enc(cfg_n);
                    r_enc_m  <= f_enc(cfg_m);
                    r_enc_c0 <= f_enc(cfg_c0);
                    r_enc_c1 <= f_enc(cfg_c1);
                    r_busy   <= 1'b1;
                    r_error  <= 1'b0;
                    // Mode write issued straight from IDLE so it lands in the next cycle.
                    r_write  <= 1'b1;
                    r_addr   <= 6'd0;
                    r_wdata  <= 32'd1;
                    r_state  <= S_MODE;
                end
                // Each write: issue, hold through waitrequest, then one idle cycle.
                S_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_START: begin
                    if (!r_write) begin
                        r_write <= 1'b1;
                        r_addr  <= w_addr;
                        r_wdata <= w_data;
                    end else if (!mgmt_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= w_next;
                        if (w_next == S_POLL) r_to <= 20'd0;
                    end
                end
                S_POLL: begin
                    if (r_to == LOCK_TIMEOUT - 20'd1) begin
                        r_read  <= 1'b0;
                        r_state <= S_ERR;
                    end else begin
                        r_to <= r_to + 20'd1;
                        if (!r_read) begin
                            r_read <= 1'b1;
                            r_addr <= 6'd1;
                        end else if (!mgmt_waitrequest) begin
                            r_read <= 1'b0;
                            if (mgmt_readdata[0]) begin
                                r_lcnt  <= 4'd0;
                                r_state <= S_LOCK;
                            end
                        end
                    end
                end
                // Lock must be seen for 16 consecutive cycles; any drop restarts.
                S_LOCK: begin
                    if (r_to == LOCK_TIMEOUT - 20'd1) begin
                        r_state <= S_ERR;
                    end else begin
                        r_to <= r_to + 20'd1;
                        if (!r_lock_s2)            r_lcnt  <= 4'd0;
                        else if (r_lcnt == 4'd15)  r_state <= S_DONE;
                        else                       r_lcnt  <= r_lcnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomized bench for pll_reconfig_ctrl. A responder models the reconfig
// core (waitrequest stalls, status reads). A monitor records accepted bus
// transfers and checks the handshake rules. Expected writes and timings are
// computed from the divider encoding rules.
module tb_pll_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_n = 8'd0, cfg_m = 8'd0, cfg_c0 = 8'd0, cfg_c1 = 8'd0;
    logic        busy, done, error;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] rdata = 32'd0;
    logic        wrq = 1'b0;
    logic        pll_locked = 1'b1;

    pll_reconfig_ctrl #(.LOCK_TIMEOUT(20'd100)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
        .busy(busy), .done(done), .error(error),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(rdata),
        .mgmt_waitrequest(wrq), .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference encoding straight from the divider rules.
    function automatic int unsigned enc(input int d);
        int v;
        v = (d == 0) ? 1 : d;
        return ((v % 2) << 17) | ((v == 1 ? 1 : 0) << 16) | (((v + 1) / 2) << 8) | (v / 2);
    endfunction

    // ---------------- responder (reconfig core model) ----------------
    int rnd_max = 0;      // max random stall cycles per transfer
    int stall_m = 0;      // stall the M-counter write for 5 cycles
    int zero_left = 0;    // status reads returning 0 before a 1
    int stall = 0;
    logic xfer_on = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!(mgmt_write || mgmt_read)) xfer_on = 1'b0;
        else if (!xfer_on) begin
            xfer_on = 1'b1;
            if (stall_m != 0 && mgmt_write && mgmt_address == 6'd4) stall = 5;
            else stall = $urandom_range(rnd_max, 0);
        end
        if (xfer_on && stall > 0) begin
            wrq = 1'b1;
            stall--;
        end else wrq = 1'b0;
        rdata = $urandom & 32'hFFFF_FFFE;
        if (mgmt_read && !wrq) begin
            if (zero_left > 0) zero_left--;
            else rdata[0] = 1'b1;
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
    wr_t wq[$];
    int rd_cnt, done_cnt, w4_cyc;
    int first_wr = -1, first_rd = -1, last_rd = -1, ok_rd = -1, done_cyc = -1;
    logic p_stall = 1'b0, p_cmpl = 1'b0;
    logic [39:0] p_bus = 40'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_stall = 1'b0;
            p_cmpl  = 1'b0;
        end else begin
            chk("rw_excl", 64'(mgmt_write & mgmt_read), 64'd0);
            if (p_stall) chk("stall_hold", 64'({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 64'(p_bus));
            if (p_cmpl)  chk("idle_gap", 64'(mgmt_write | mgmt_read), 64'd0);
            if (mgmt_write && mgmt_address == 6'd4) w4_cyc++;
            if (mgmt_write && !wrq) begin
                wq.push_back({mgmt_address, mgmt_writedata});
                if (first_wr < 0) first_wr = cyc;
            end
            if (mgmt_read && !wrq) begin
                rd_cnt++;
                chk("rd_addr", 64'(mgmt_address), 64'd1);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (rdata[0]) ok_rd = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            p_stall = (mgmt_write || mgmt_read) && wrq;
            p_cmpl  = (mgmt_write || mgmt_read) && !wrq;
            p_bus   = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
        end
    end

    // ---------------- sequencing ----------------
    int glitch_en = 0, rise_cyc = -1;

    task automatic start(input logic [7:0] n, input logic [7:0] m, input logic [7:0] c0, input logic [7:0] c1);
        wq.delete();
        rd_cnt = 0; done_cnt = 0; w4_cyc = 0;
        first_wr = -1; first_rd = -1; last_rd = -1; ok_rd = -1; done_cyc = -1; rise_cyc = -1;
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("busy_on_start", 64'(busy), 64'd1);
        chk("error_cleared", 64'(error), 64'd0);
        // Later input changes must have no effect.
        cfg_n = 8'($urandom); cfg_m = 8'($urandom); cfg_c0 = 8'($urandom); cfg_c1 = 8'($urandom);
    endtask

    // Returns 1 on done, 2 on error, 0 if the cycle budget expires.
    task automatic wait_end(output int st);
        st = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            cfg_start = (i == 4);   // request while busy: must be ignored
            if (glitch_en != 0 && ok_rd >= 0) begin
                if (cyc == ok_rd + 11) pll_locked = 1'b0;
                if (cyc == ok_rd + 14) begin pll_locked = 1'b1; rise_cyc = cyc; end
            end
            if (done)  begin st = 1; break; end
            if (error) begin st = 2; break; end
        end
        cfg_start = 1'b0;
        if (st == 0) chk("wait_bound", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic check_writes(input int n, input int m, input int c0, input int c1);
        int unsigned ed[6];
        logic [5:0]  ea[6];
        ea = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd5, 6'd2};
        ed[0] = 1; ed[1] = enc(n); ed[2] = enc(m);
        ed[3] = enc(c0); ed[4] = enc(c1) | (1 << 18); ed[5] = 0;
        chk("wr_count", 64'(wq.size()), 64'd6);
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            chk($sformatf("wr%0d_addr", i), 64'(wq[i].a), 64'(ea[i]));
            chk($sformatf("wr%0d_data", i), 64'(wq[i].d), 64'(ed[i]));
        end
    endtask

    task automatic run_ok(input logic [7:0] n, input logic [7:0] m, input logic [7:0] c0,
                          input logic [7:0] c1, input int zeros);
        int st;
        zero_left = zeros;
        start(n, m, c0, c1);
        wait_end(st);
        chk("end_done", 64'(st), 64'd1);
        check_writes(n, m, c0, c1);
        chk("rd_count", 64'(rd_cnt), 64'(zeros + 1));
        chk("busy_after", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done_cnt), 64'd1);
    endtask

    function automatic logic [7:0] rnd_d();
        int r;
        r = $urandom_range(9, 0);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd1;
        if (r == 2) return 8'd255;
        return 8'($urandom_range(255, 2));
    endfunction

    initial begin
        int st;
        #1;
        chk("rst_outputs", 64'({busy, done, error, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 64'({busy, done, error, mgmt_write, mgmt_read}), 64'd0);

        // Zero-wait directed run: first poll read 12 cycles after the mode write.
        // LOCK entered one cycle after the successful read, done 17 cycles later.
        run_ok(8'd1, 8'd24, 8'd30, 8'd5, 0);
        chk("lat_first_rd", 64'(first_rd - first_wr), 64'd12);
        chk("lat_done", 64'(done_cyc - first_wr), 64'd30);

        // M-counter write stalled 5 cycles: 6 write cycles, one acceptance.
        stall_m = 1;
        run_ok(8'd7, 8'd40, 8'd3, 8'd2, 0);
        chk("stall_w4_cycles", 64'(w4_cyc), 64'd6);
        stall_m = 0;

        // Three not-done status reads, reads two cycles apart.
        run_ok(8'd2, 8'd16, 8'd8, 8'd12, 3);
        chk("poll_spacing", 64'(last_rd - first_rd), 64'd6);

        // Lock glitch 10 cycles into LOCK: 2 sync + 16 count + 1 DONE after the rise.
        glitch_en = 1;
        run_ok(8'd3, 8'd20, 8'd10, 8'd4, 0);
        glitch_en = 0;
        chk("glitch_done", 64'(done_cyc - rise_cyc), 64'd19);

        // Timeout: 100 POLL cycles starting 11 after the mode write, then ERR.
        zero_left = 1000000;
        start(8'd5, 8'd6, 8'd7, 8'd8);
        wait_end(st);
        chk("to_status", 64'(st), 64'd2);
        chk("to_latency", 64'(cyc - first_wr), 64'd112);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_no_done", 64'(done_cnt), 64'd0);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(error), 64'd1);
        run_ok(8'd9, 8'd11, 8'd13, 8'd15, 1);

        // Reset while the C0 write is on the bus.
        zero_left = 0;
        start(8'd4, 8'd5, 8'd6, 8'd7);
        st = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (mgmt_write && mgmt_address == 6'd5) begin st = 1; break; end
        end
        chk("saw_c0_write", 64'(st), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({busy, done, error, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'd0);
        run_ok(8'd1, 8'd24, 8'd30, 8'd5, 0);

        // Randomized runs with bus stalls and a few not-done polls.
        rnd_max = 2;
        for (int k = 0; k < 10; k++)
            run_ok(rnd_d(), rnd_d(), rnd_d(), rnd_d(), int'($urandom_range(3, 0)));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
